// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller (dmem_ctrl).
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic WE_STORE = 1'b1;
    localparam logic WE_LOAD  = 1'b0;

    // Latency counter only ever holds LATENCY-1 down to 1.
    function automatic int unsigned cnt_width(input int unsigned latency);
        if (latency <= 32'd2) return 32'd1;
        return unsigned'($clog2(latency));
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core <-> data-memory controller bus. err_o exists only when DMEM_RANGE_CHK_EN is defined.
interface dmem_ctrl_if;

    logic        req_i;
    logic        we_re_i;
    logic [3:0]  mask_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        valid_o;
    logic        busy_o;
`ifdef DMEM_RANGE_CHK_EN
    logic        err_o;
`endif

    modport master (
        output req_i, we_re_i, mask_i, addr_i, wdata_i,
        input  rdata_o, valid_o, busy_o
`ifdef DMEM_RANGE_CHK_EN
        , input err_o
`endif
    );

    modport slave (
        input  req_i, we_re_i, mask_i, addr_i, wdata_i,
        output rdata_o, valid_o, busy_o
`ifdef DMEM_RANGE_CHK_EN
        , output err_o
`endif
    );

endinterface

// File: rtl/dmem_sram_bank.sv
// Single-port DEPTH x 32-bit array built from four byte lanes; synchronous write and read.
module dmem_sram_bank #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [3:0][7:0] mem_q [DEPTH];
    logic [31:0]     rdata_q;

    // Contents are deliberately not reset; the read register holds between reads.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) mem_q[addr_i][b] <= wdata_i[8*b +: 8];
        end
        if (rd_en_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one outstanding access, fixed LATENCY, byte-lane SRAM behind it.
// Optional out-of-range checking is enabled by defining DMEM_RANGE_CHK_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);

    localparam int unsigned      ADDR_W   = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [3:0]         mask_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [31:0]        wdata_q;
    logic               oob_q;
    logic               rd_zero_q;

    logic               idle, capture, commit;
    logic               live_oob;
    logic               c_we, c_oob;
    logic [3:0]         c_mask;
    logic [ADDR_W-1:0]  c_idx;
    logic [31:0]        c_wdata;
    logic               sram_we, sram_re;
    logic [31:0]        sram_rdata;
    logic               unused_addr_bits;

`ifdef DMEM_RANGE_CHK_EN
    assign live_oob         = |bus.addr_i[31:ADDR_W+2];
    assign unused_addr_bits = ^bus.addr_i[1:0];
`else
    assign live_oob         = 1'b0;
    assign unused_addr_bits = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With LATENCY==1 the commit edge is the accept edge, so IDLE uses the live request fields.
    assign idle    = (state_q == ST_IDLE);
    assign c_we    = idle ? bus.we_re_i                 : we_q;
    assign c_mask  = idle ? bus.mask_i                  : mask_q;
    assign c_idx   = idle ? bus.addr_i[ADDR_W+1:2]      : idx_q;
    assign c_wdata = idle ? bus.wdata_i                 : wdata_q;
    assign c_oob   = idle ? live_oob                    : oob_q;

    assign sram_we = commit && (c_we == WE_STORE) && !c_oob;
    assign sram_re = commit && (c_we == WE_LOAD)  && !c_oob;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= WE_LOAD;
            mask_q    <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            oob_q     <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= bus.we_re_i;
                mask_q  <= bus.mask_i;
                idx_q   <= bus.addr_i[ADDR_W+1:2];
                wdata_q <= bus.wdata_i;
                oob_q   <= live_oob;
            end
            if (commit && (c_we == WE_LOAD)) rd_zero_q <= c_oob;
        end
    end

`ifdef DMEM_RANGE_CHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= commit && c_oob;
    end

    assign bus.err_o = err_q;
`endif

    dmem_sram_bank #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .we_i    (sram_we),
        .be_i    (c_mask),
        .rd_en_i (sram_re),
        .addr_i  (c_idx),
        .wdata_i (c_wdata),
        .rdata_o (sram_rdata)
    );

    assign bus.rdata_o = rd_zero_q ? '0 : sram_rdata;
    assign bus.valid_o = (state_q == ST_RESP);
    assign bus.busy_o  = !idle;

endmodule
